// File: rtl/gene_net_seq.sv
// Run controller for the 8-gene Boolean network update core: seeds the core, steps it once per clock,
// and stops on a fixed point, a short attractor cycle, or step-budget exhaustion.
// Optional trace port enabled by defining GENE_NET_SEQ_TRACE_EN.
module gene_net_seq #(
    parameter int unsigned W          = 8,
    parameter int unsigned STEP_W     = 8,
    parameter int unsigned HIST_DEPTH = 7
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [W-1:0]      seed,
    input  logic [STEP_W-1:0] max_steps,
    output logic [W-1:0]      cur_state,
    input  logic [W-1:0]      nxt_state,
    output logic              busy,
    output logic              done,
    output logic [1:0]        result,
    output logic [3:0]        period,
    output logic [STEP_W-1:0] steps,
    output logic [W-1:0]      final_state
`ifdef GENE_NET_SEQ_TRACE_EN
    ,
    output logic              trace_valid,
    output logic [W-1:0]      trace_state
`endif
);

    localparam int unsigned IDX_W = (HIST_DEPTH > 1) ? $clog2(HIST_DEPTH) : 1;

    localparam logic [1:0] RES_TIMEOUT = 2'd0;
    localparam logic [1:0] RES_FIXED   = 2'd1;
    localparam logic [1:0] RES_CYCLE   = 2'd2;

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_STEP,
        S_DONE
    } state_t;

    state_t                         state_q, state_d;
    logic [W-1:0]                   seed_q, seed_d;
    logic [STEP_W-1:0]              max_q, max_d;
    logic [HIST_DEPTH-1:0][W-1:0]   hist_q, hist_d;
    logic [HIST_DEPTH-1:0]          hv_q, hv_d;
    logic [W-1:0]                   cur_d, final_d;
    logic                           busy_d, done_d;
    logic [1:0]                     result_d;
    logic [3:0]                     period_d;
    logic [STEP_W-1:0]              steps_d, steps_inc;
    logic                           hit_fix, hit_cyc;
    logic [IDX_W-1:0]               hit_idx;
`ifdef GENE_NET_SEQ_TRACE_EN
    logic                           trace_valid_d;
    logic [W-1:0]                   trace_state_d;
`endif

    // History match: scan oldest to newest so the most recent (smallest index) hit wins.
    always_comb begin
        hit_fix = (nxt_state == cur_state);
        hit_cyc = 1'b0;
        hit_idx = '0;
        for (int i = int'(HIST_DEPTH) - 1; i >= 0; i--) begin
            if (hv_q[i] && (hist_q[i] == nxt_state)) begin
                hit_cyc = 1'b1;
                hit_idx = IDX_W'(i);
            end
        end
    end

    assign steps_inc = steps + STEP_W'(1);

    // Next-state and registered-output computation.
    always_comb begin
        state_d  = state_q;
        seed_d   = seed_q;
        max_d    = max_q;
        hist_d   = hist_q;
        hv_d     = hv_q;
        cur_d    = cur_state;
        final_d  = final_state;
        result_d = result;
        period_d = period;
        steps_d  = steps;
        done_d   = 1'b0;
`ifdef GENE_NET_SEQ_TRACE_EN
        trace_valid_d = 1'b0;
        trace_state_d = trace_state;
`endif

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    seed_d  = seed;
                    max_d   = max_steps;
                    state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                cur_d   = seed_q;
                steps_d = '0;
                hv_d    = '0;
                if (max_q == '0) begin
                    state_d  = S_DONE;
                    done_d   = 1'b1;
                    result_d = RES_TIMEOUT;
                    period_d = 4'd0;
                    final_d  = seed_q;
                end else begin
                    state_d = S_STEP;
                end
            end
            S_STEP: begin
                if (hit_fix) begin
                    state_d  = S_DONE;
                    done_d   = 1'b1;
                    result_d = RES_FIXED;
                    period_d = 4'd1;
                    final_d  = cur_state;
                end else if (hit_cyc) begin
                    state_d  = S_DONE;
                    done_d   = 1'b1;
                    result_d = RES_CYCLE;
                    period_d = 4'(hit_idx) + 4'd2;
                    final_d  = cur_state;
                end else begin
                    hist_d  = {hist_q[HIST_DEPTH-2:0], cur_state};
                    hv_d    = {hv_q[HIST_DEPTH-2:0], 1'b1};
                    cur_d   = nxt_state;
                    steps_d = steps_inc;
`ifdef GENE_NET_SEQ_TRACE_EN
                    trace_valid_d = 1'b1;
                    trace_state_d = nxt_state;
`endif
                    if (steps_inc == max_q) begin
                        state_d  = S_DONE;
                        done_d   = 1'b1;
                        result_d = RES_TIMEOUT;
                        period_d = 4'd0;
                        final_d  = nxt_state;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        busy_d = (state_d == S_LOAD) || (state_d == S_STEP);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            seed_q      <= '0;
            max_q       <= '0;
            hist_q      <= '0;
            hv_q        <= '0;
            cur_state   <= '0;
            final_state <= '0;
            result      <= '0;
            period      <= '0;
            steps       <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
        end else begin
            state_q     <= state_d;
            seed_q      <= seed_d;
            max_q       <= max_d;
            hist_q      <= hist_d;
            hv_q        <= hv_d;
            cur_state   <= cur_d;
            final_state <= final_d;
            result      <= result_d;
            period      <= period_d;
            steps       <= steps_d;
            busy        <= busy_d;
            done        <= done_d;
        end
    end

`ifdef GENE_NET_SEQ_TRACE_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            trace_valid <= 1'b0;
            trace_state <= '0;
        end else begin
            trace_valid <= trace_valid_d;
            trace_state <= trace_state_d;
        end
    end
`endif

endmodule

// File: tb/tb_gene_net_seq.sv
// Self-checking bench for gene_net_seq: table-driven update core, trajectory-search reference model.
module tb_gene_net_seq;

    localparam int MAX_PERIOD = 8;
    localparam int BUDGET     = 600;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic [7:0] seed = 8'h00;
    logic [7:0] max_steps = 8'h00;
    logic [7:0] cur_state;
    logic [7:0] nxt_state;
    logic       busy, done;
    logic [1:0] result;
    logic [3:0] period;
    logic [7:0] steps;
    logic [7:0] final_state;

    logic [7:0] tbl [256];
    int n_checks = 0;
    int n_fail   = 0;

    gene_net_seq dut (
        .clk(clk), .rst_n(rst_n), .start(start), .seed(seed), .max_steps(max_steps),
        .cur_state(cur_state), .nxt_state(nxt_state), .busy(busy), .done(done),
        .result(result), .period(period), .steps(steps), .final_state(final_state)
    );

    assign nxt_state = tbl[cur_state];

    always #5 clk = ~clk;

    // Update core: random funnel into a 16-state region, plus the reference trajectory.
    task automatic build_core();
        for (int i = 0; i < 256; i++) begin
            if (i < 16) tbl[i] = 8'($urandom_range(0, 15));
            else        tbl[i] = 8'($urandom_range(0, i - 1));
        end
        tbl[8'h00] = 8'h00; tbl[8'h80] = 8'h04; tbl[8'h04] = 8'h20;
        tbl[8'h20] = 8'h02; tbl[8'h02] = 8'h58; tbl[8'h58] = 8'h93;
        tbl[8'h93] = 8'h1C; tbl[8'h1C] = 8'hB2; tbl[8'hB2] = 8'h1C;
    endtask

    // Reference: walk the trajectory, stop when the next state revisits one of the last MAX_PERIOD states.
    task automatic model_run(input logic [7:0] s, input logic [7:0] m,
                             output logic [1:0] r, output logic [3:0] p,
                             output logic [7:0] st, output logic [7:0] fs, output int lat);
        logic [7:0] traj [$];
        logic [7:0] n;
        int found;
        traj.push_back(s);
        r = 2'd0; p = 4'd0; st = 8'd0; fs = s; lat = 2;
        if (m == 8'd0) return;
        for (int t = 0; t < 256; t++) begin
            n = tbl[traj[t]];
            found = -1;
            for (int j = t; j >= 0 && (t + 1 - j) <= MAX_PERIOD; j--) begin
                if (found < 0 && traj[j] == n) found = j;
            end
            if (found >= 0) begin
                p   = 4'(t + 1 - found);
                r   = (p == 4'd1) ? 2'd1 : 2'd2;
                st  = 8'(t);
                fs  = traj[t];
                lat = t + 3;
                return;
            end
            traj.push_back(n);
            if (t + 1 == int'(m)) begin
                r = 2'd0; p = 4'd0; st = m; fs = n; lat = int'(m) + 2;
                return;
            end
        end
    endtask

    // Issue one run and collect what the DUT reports; lat=-1 if done never arrives.
    task automatic run_dut(input logic [7:0] s, input logic [7:0] m, input int inject_cyc,
                           output int lat, output logic busy_load,
                           output logic [1:0] g_r, output logic [3:0] g_p, output logic [7:0] g_st,
                           output logic [7:0] g_fs, output logic [7:0] g_cs,
                           output logic done_after, output logic busy_after);
        @(negedge clk);
        start = 1'b1; seed = s; max_steps = m;
        @(negedge clk);
        start = 1'b0; seed = 8'($urandom); max_steps = 8'($urandom);
        busy_load = busy;
        lat = 1;
        while (!done && lat < BUDGET) begin
            if (lat == inject_cyc) begin
                start = 1'b1; seed = 8'h00; max_steps = 8'd1;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            lat++;
        end
        start = 1'b0;
        if (!done) lat = -1;
        g_r = result; g_p = period; g_st = steps; g_fs = final_state; g_cs = cur_state;
        @(negedge clk);
        done_after = done;
        busy_after = busy;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++; if (cur_state !== 8'h00) begin n_fail++; $display("FAIL reset_cur_state: got %0h expected 0", cur_state); end
        n_checks++; if (final_state !== 8'h00) begin n_fail++; $display("FAIL reset_final_state: got %0h expected 0", final_state); end
        n_checks++; if (steps !== 8'h00) begin n_fail++; $display("FAIL reset_steps: got %0h expected 0", steps); end
        n_checks++; if ({result, period} !== 6'h00) begin n_fail++; $display("FAIL reset_result_period: got %0h/%0h expected 0/0", result, period); end
        n_checks++; if ({busy, done} !== 2'b00) begin n_fail++; $display("FAIL reset_busy_done: got %b%b expected 00", busy, done); end
        rst_n = 1'b1;
    endtask

    task automatic test_fixed_point();
        int lat; logic bl, da, ba; logic [1:0] r; logic [3:0] p; logic [7:0] st, fs, cs;
        run_dut(8'h00, 8'd10, -1, lat, bl, r, p, st, fs, cs, da, ba);
        n_checks++; if (lat !== 3) begin n_fail++; $display("FAIL fixed_latency: got %0d expected 3", lat); end
        n_checks++; if (bl !== 1'b1) begin n_fail++; $display("FAIL fixed_busy_load: got %b expected 1", bl); end
        n_checks++; if ({r, p, st, fs} !== {2'd1, 4'd1, 8'd0, 8'h00}) begin n_fail++;
            $display("FAIL fixed_outputs: got r=%0d p=%0d st=%0d fs=%0h expected 1/1/0/00", r, p, st, fs); end
        n_checks++; if ({da, ba} !== 2'b00) begin n_fail++; $display("FAIL fixed_done_pulse: got done=%b busy=%b expected 0/0", da, ba); end
    endtask

    task automatic test_cycle();
        int lat; logic bl, da, ba; logic [1:0] r; logic [3:0] p; logic [7:0] st, fs, cs;
        run_dut(8'h80, 8'd20, -1, lat, bl, r, p, st, fs, cs, da, ba);
        n_checks++; if (lat !== 10) begin n_fail++; $display("FAIL cycle_latency: got %0d expected 10", lat); end
        n_checks++; if ({r, p, st, fs} !== {2'd2, 4'd2, 8'd7, 8'hB2}) begin n_fail++;
            $display("FAIL cycle_outputs: got r=%0d p=%0d st=%0d fs=%0h expected 2/2/7/b2", r, p, st, fs); end
        n_checks++; if (cs !== 8'hB2) begin n_fail++; $display("FAIL cycle_cur_state: got %0h expected b2", cs); end
        repeat (3) @(negedge clk);
        n_checks++; if ({done, result, period, steps, final_state} !== {1'b0, 2'd2, 4'd2, 8'd7, 8'hB2}) begin n_fail++;
            $display("FAIL cycle_hold: got d=%b r=%0d p=%0d st=%0d fs=%0h", done, result, period, steps, final_state); end
    endtask

    task automatic test_timeout();
        int lat; logic bl, da, ba; logic [1:0] r; logic [3:0] p; logic [7:0] st, fs, cs;
        run_dut(8'h80, 8'd3, -1, lat, bl, r, p, st, fs, cs, da, ba);
        n_checks++; if (lat !== 5) begin n_fail++; $display("FAIL timeout_latency: got %0d expected 5", lat); end
        n_checks++; if ({r, p, st, fs} !== {2'd0, 4'd0, 8'd3, 8'h02}) begin n_fail++;
            $display("FAIL timeout_outputs: got r=%0d p=%0d st=%0d fs=%0h expected 0/0/3/02", r, p, st, fs); end
    endtask

    task automatic test_zero_budget();
        int lat; logic bl, da, ba; logic [1:0] r; logic [3:0] p; logic [7:0] st, fs, cs;
        run_dut(8'h5A, 8'd0, -1, lat, bl, r, p, st, fs, cs, da, ba);
        n_checks++; if (lat !== 2) begin n_fail++; $display("FAIL zero_latency: got %0d expected 2", lat); end
        n_checks++; if ({r, p, st, fs, cs} !== {2'd0, 4'd0, 8'd0, 8'h5A, 8'h5A}) begin n_fail++;
            $display("FAIL zero_outputs: got r=%0d p=%0d st=%0d fs=%0h cs=%0h expected 0/0/0/5a/5a", r, p, st, fs, cs); end
    endtask

    task automatic test_start_ignored();
        int lat; logic bl, da, ba; logic [1:0] r; logic [3:0] p; logic [7:0] st, fs, cs;
        run_dut(8'h80, 8'd20, 4, lat, bl, r, p, st, fs, cs, da, ba);
        n_checks++; if (lat !== 10) begin n_fail++; $display("FAIL ignored_latency: got %0d expected 10", lat); end
        n_checks++; if ({r, p, st, fs} !== {2'd2, 4'd2, 8'd7, 8'hB2}) begin n_fail++;
            $display("FAIL ignored_outputs: got r=%0d p=%0d st=%0d fs=%0h expected 2/2/7/b2", r, p, st, fs); end
    endtask

    task automatic test_reset_mid_run();
        int lat; logic bl, da, ba; logic [1:0] r; logic [3:0] p; logic [7:0] st, fs, cs;
        logic saw_done;
        @(negedge clk);
        start = 1'b1; seed = 8'h80; max_steps = 8'd20;
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        n_checks++; if ({busy, steps} !== {1'b1, 8'd4}) begin n_fail++; $display("FAIL midrun_progress: got busy=%b steps=%0d expected 1/4", busy, steps); end
        #2 rst_n = 1'b0;
        #1;
        n_checks++; if ({busy, done, result, period, steps, cur_state, final_state} !== '0) begin n_fail++;
            $display("FAIL midrun_reset_clear: got b=%b d=%b r=%0d p=%0d st=%0d cs=%0h fs=%0h", busy, done, result, period, steps, cur_state, final_state); end
        saw_done = 1'b0;
        repeat (3) begin @(negedge clk); saw_done |= done; end
        rst_n = 1'b1;
        repeat (2) begin @(negedge clk); saw_done |= done; end
        n_checks++; if (saw_done !== 1'b0) begin n_fail++; $display("FAIL midrun_no_done: got %b expected 0", saw_done); end
        run_dut(8'h80, 8'd20, -1, lat, bl, r, p, st, fs, cs, da, ba);
        n_checks++; if (lat !== 10 || {r, p, st, fs} !== {2'd2, 4'd2, 8'd7, 8'hB2}) begin n_fail++;
            $display("FAIL midrun_rerun: got lat=%0d r=%0d p=%0d st=%0d fs=%0h expected 10/2/2/7/b2", lat, r, p, st, fs); end
    endtask

    task automatic test_random();
        int lat, e_lat; logic bl, da, ba; logic [1:0] r, e_r; logic [3:0] p, e_p;
        logic [7:0] st, fs, cs, e_st, e_fs, s, m;
        for (int k = 0; k < 40; k++) begin
            s = 8'($urandom_range(0, 255));
            m = 8'($urandom_range(0, 40));
            model_run(s, m, e_r, e_p, e_st, e_fs, e_lat);
            run_dut(s, m, -1, lat, bl, r, p, st, fs, cs, da, ba);
            n_checks++; if (lat !== e_lat) begin n_fail++; $display("FAIL rand_latency[%0d] seed=%0h max=%0d: got %0d expected %0d", k, s, m, lat, e_lat); end
            n_checks++; if ({r, p} !== {e_r, e_p}) begin n_fail++; $display("FAIL rand_result[%0d] seed=%0h: got r=%0d p=%0d expected r=%0d p=%0d", k, s, r, p, e_r, e_p); end
            n_checks++; if ({st, fs, cs} !== {e_st, e_fs, e_fs}) begin n_fail++;
                $display("FAIL rand_state[%0d] seed=%0h: got st=%0d fs=%0h cs=%0h expected st=%0d fs=%0h", k, s, st, fs, cs, e_st, e_fs); end
            n_checks++; if ({bl, da, ba} !== 3'b100) begin n_fail++; $display("FAIL rand_handshake[%0d]: got busy_load=%b done_after=%b busy_after=%b expected 1/0/0", k, bl, da, ba); end
        end
    endtask

    initial begin
        build_core();
        test_reset();
        test_fixed_point();
        test_cycle();
        test_timeout();
        test_zero_budget();
        test_start_ignored();
        test_reset_mid_run();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/gene_net_seq.md
Name: gene_net_seq

Overview:
- Run controller for the 8-gene Boolean network update core.
- Loads a seed state, applies the core's next-state function once per clock, and stops on one of three events: fixed point, short cycle (attractor), or step budget exhausted.
- Drives the core's current-state input and samples its combinational next-state output.
- Reports attractor type, period, step count and final state to the host/testbench layer.

Parameters:
- W, 8, state width (number of genes).
- STEP_W, 8, width of max_steps and steps.
- HIST_DEPTH, 7, previous states retained for cycle detection; max detectable period = HIST_DEPTH+1.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  run request; sampled only in IDLE or DONE.
- seed  in  W  initial network state; captured with start.
- max_steps  in  STEP_W  transition budget; captured with start.
- cur_state  out  W  state presented to the update core.
- nxt_state  in  W  core's combinational next state for cur_state.
- busy  out  1  high in LOAD and STEP.
- done  out  1  one-cycle pulse on entry to DONE.
- result  out  2  0=timeout, 1=fixed point, 2=cycle, 3=unused.
- period  out  4  attractor period (1 for fixed point, 0 for timeout).
- steps  out  STEP_W  transitions taken before stop.
- final_state  out  W  cur_state at stop.

Behaviour:
- Reset (async, rst_n=0): FSM=IDLE. cur_state, final_state, steps, period, result=0. busy=0, done=0. History valid bits cleared.
- FSM states: IDLE, LOAD, STEP, DONE.
- IDLE/DONE + start=1: capture seed and max_steps, go to LOAD. start while busy is ignored.
- LOAD (1 cycle):
  - cur_state<=seed, steps<=0, history valid cleared.
  - If max_steps==0: go to DONE with result=0, period=0, final_state=seed.
  - Otherwise go to STEP.
- STEP: each cycle compare nxt_state against cur_state and against valid history entries h[0..HIST_DEPTH-1], where h[0] is the most recent previous state.
  - nxt_state==cur_state: fixed point. result=1, period=1.
  - Else nxt_state==h[i] (smallest valid i wins): cycle. result=2, period=i+2.
  - Any match: go to DONE, final_state=cur_state, steps unchanged.
  - No match: shift cur_state into h[0] (oldest entry dropped), cur_state<=nxt_state, steps<=steps+1.
  - If steps+1==max_steps: go to DONE with result=0, period=0, final_state=nxt_state.
- DONE:
  - done=1 for the entry cycle only.
  - result, period, steps and final_state hold until the next LOAD.
  - cur_state holds.
- Latency: start to first STEP = 2 cycles. A run of n transitions ending in detection asserts done n+3 cycles after start.
- steps never wraps; the budget stops the run first.
- Cycles longer than HIST_DEPTH+1 report timeout.
- Reset mid-run aborts immediately. No done is issued.

Optional Feature:
- GENE_NET_SEQ_TRACE_EN defined:
  - Adds outputs trace_valid (1) and trace_state (W).
  - trace_valid pulses in every STEP cycle that takes a transition, with trace_state=nxt_state.
  - Both outputs are 0 after reset.
- Undefined: ports absent, no trace logic.

Test Plan (update core = the standard 8-gene network):
- seed=0x00, max_steps=10 -> done after 3 cycles; result=1, period=1, steps=0, final_state=0x00.
- seed=0x80, max_steps=20 -> trajectory 80,04,20,02,58,93,1C,B2; result=2, period=2, steps=7, final_state=0xB2.
- seed=0x80, max_steps=3 -> result=0, period=0, steps=3, final_state=0x02.
- max_steps=0, seed=0x5A -> DONE via LOAD; result=0, steps=0, final_state=0x5A.
- seed=0x80 run, pulse start at step 2 -> ignored; run completes as in the max_steps=20 case.
- seed=0x80 run, drop rst_n at step 4 -> outputs zero at once, no done pulse; a new start after release runs normally.
